mealy_probe: RTL and testbench
==============================

Name: mealy_probe

Overview:
- Table-driven stimulus generator and checker for the team's small Mealy FSM blocks. It sits on the driving side of their interface: it produces the FSM's reset, preload state, switch input and step enable, then captures the FSM's state and out.
- It sweeps every (state, input) pair, checks each step against a programmed expected-transition table, and reports pass/fail plus the first mismatch.

Parameters:
- NUM_STATES, 2, number of FSM states to sweep (1..8).
- SW_W, 2, width of the FSM switch input.
- STATE_W, 3, width of the FSM state bus.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  expected-table write strobe.
- cfg_state  in  STATE_W  table row (state).
- cfg_sw  in  SW_W  table column (input).
- cfg_next  in  STATE_W  expected next state.
- cfg_out  in  1  expected out.
- start  in  1  one-cycle sweep request.
- dut_reset  out  1  active-high preload to FSM.
- dut_state_in  out  STATE_W  preload state.
- dut_sw  out  SW_W  FSM switch input.
- dut_ctrl  out  1  FSM step enable.
- dut_state  in  STATE_W  FSM registered state.
- dut_out  in  1  FSM registered out.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  last sweep had zero mismatches; held until next start.
- err_cnt  out  ERR_W  mismatches in last/current sweep; saturates at all-ones.
- first_err_valid  out  1  first_err_* fields are meaningful.
- first_err_state  out  STATE_W  preload state of the first mismatch.
- first_err_sw  out  SW_W  input of the first mismatch.
- first_err_kind  out  2  bit0 = next-state mismatch, bit1 = out mismatch.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0.
  - FSM to IDLE, sweep indices 0.
  - Expected table cleared to next=0, out=0.
  - Reset mid-sweep aborts the sweep immediately; no done pulse.
- Table:
  - NUM_STATES x 2^SW_W entries of {next, out}.
  - A write takes effect on the clock edge where cfg_we=1.
  - Writes are ignored while busy=1, and ignored if cfg_state >= NUM_STATES.
- States: IDLE, PRELOAD, SETTLE, STEP, CHECK, DONE.
- IDLE:
  - start=1 moves to PRELOAD.
  - On entry to PRELOAD: busy=1, pass=0, err_cnt=0, first_err_valid=0, s=0, i=0.
- PRELOAD (1 cycle): dut_reset=1, dut_state_in=s, dut_sw=i, dut_ctrl=0.
- SETTLE (1 cycle): dut_reset=0; dut_sw=i held.
- STEP (1 cycle): dut_ctrl=1, dut_sw=i.
- CHECK (1 cycle): dut_ctrl=0. Compare dut_state with table[s][i].next and dut_out with table[s][i].out.
  - On mismatch, err_cnt increments (saturating).
  - If first_err_valid=0, latch s, i and kind, and set first_err_valid=1.
  - Then advance: i wraps 2^SW_W-1 -> 0 with s+1. After s=NUM_STATES-1 and i=all-ones, go to DONE; otherwise go to PRELOAD.
- DONE (1 cycle): done=1, busy=0, pass=(err_cnt==0), then return to IDLE.
- Outside PRELOAD/SETTLE/STEP, dut_* outputs are 0.
- Timing: 4 cycles per pair. Sweep latency from the start edge to the done pulse is 4*NUM_STATES*2^SW_W+1 cycles.
- start while busy is ignored. start in the DONE cycle is ignored.
- dut_out is compared only in CHECK, never after preload, because the FSM does not reset out.

Optional Feature:
- Macro: MEALY_PROBE_STOP_ON_ERR_EN.
- Defined: the first mismatch in CHECK goes straight to DONE. done pulses, pass=0, err_cnt=1, and the remaining pairs are skipped.
- Undefined: the full sweep always completes and every mismatch is counted.

Decomposition:
- Package mealy_probe_pkg:
  - FSM state enum.
  - Error-kind bit constants ERR_NEXT=0, ERR_OUT=1.
  - Entry struct {next, out}.
- Sub-module mealy_exp_table:
  - Register-file table with one synchronous write port and one combinational read port addressed by {s, i}.
  - Asynchronous active-low clear.

Test Plan:
- Load the table state0: sw0->0/1, sw1->0/0, sw2->1/1, sw3->1/1; state1: sw0->0/0, sw1->1/1, sw2->1/1, sw3->1/0. Attach a correct model and start -> done pulse at cycle 33 after the start edge, pass=1, err_cnt=0, first_err_valid=0.
- Same table, model with state0/sw2 next=0 and state1/sw0 out=1 -> pass=0, err_cnt=2, first_err_state=0, first_err_sw=2, first_err_kind=01.
- Same faulty model with MEALY_PROBE_STOP_ON_ERR_EN defined -> done at cycle 13, err_cnt=1, first_err_sw=2.
- Pulse start at cycle 5 of a sweep, and pulse cfg_we mid-sweep -> no restart, table unchanged, single done pulse.
- Drop reset during STEP of pair (1,1) -> all outputs 0 immediately, no done pulse; a new start then gives a full clean sweep with pass=1.
- Fault every pair against a 300-mismatch model with ERR_W=8 and NUM_STATES=8, SW_W=6 -> err_cnt saturates at 255.

Source files
------------

// File: rtl/mealy_probe_pkg.sv
// Shared types for the Mealy FSM probe: sweep FSM states, error-kind bits and
// the expected-transition table entry.
package mealy_probe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_SETTLE,
    ST_STEP,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int ERR_NEXT = 0;
  localparam int ERR_OUT  = 1;

  // Entries hold the widest supported state; narrower configs zero-extend.
  localparam int MAX_STATE_W = 8;

  typedef struct packed {
    logic [MAX_STATE_W-1:0] next;
    logic                   out;
  } entry_t;

endpackage

// File: rtl/mealy_probe_if.sv
// Probe <-> FSM-under-test bus. master = probe (drives stimulus), slave = FSM.
interface mealy_probe_if #(
  parameter int STATE_W = 3,
  parameter int SW_W    = 2
);
  logic               dut_reset;
  logic [STATE_W-1:0] dut_state_in;
  logic [SW_W-1:0]    dut_sw;
  logic               dut_ctrl;
  logic [STATE_W-1:0] dut_state;
  logic               dut_out;

  modport master (
    output dut_reset, dut_state_in, dut_sw, dut_ctrl,
    input  dut_state, dut_out
  );

  modport slave (
    input  dut_reset, dut_state_in, dut_sw, dut_ctrl,
    output dut_state, dut_out
  );
endinterface

// File: rtl/mealy_exp_table.sv
// Expected-transition register file: one sync write port, one comb read port,
// addressed by {state, sw}; async active-low clear to next=0/out=0.
module mealy_exp_table
  import mealy_probe_pkg::*;
#(
  parameter int NUM_STATES = 2,
  parameter int SW_W       = 2,
  parameter int STATE_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [STATE_W-1:0] wr_state_i,
  input  logic [SW_W-1:0]    wr_sw_i,
  input  entry_t             wr_data_i,
  input  logic [STATE_W-1:0] rd_state_i,
  input  logic [SW_W-1:0]    rd_sw_i,
  output entry_t             rd_data_o
);
  localparam int DEPTH = NUM_STATES << SW_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_addr, rd_addr;

  // Callers only present rows < NUM_STATES, so truncation never aliases.
  assign wr_addr   = AW'({wr_state_i, wr_sw_i});
  assign rd_addr   = AW'({rd_state_i, rd_sw_i});
  assign rd_data_o = mem_q[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (we_i) begin
      mem_q[wr_addr] <= wr_data_i;
    end
  end
endmodule

// File: rtl/mealy_probe.sv
// Table-driven stimulus/checker sweep for small Mealy FSMs.
// Optional MEALY_PROBE_STOP_ON_ERR_EN: end the sweep at the first mismatch.
module mealy_probe
  import mealy_probe_pkg::*;
#(
  parameter int NUM_STATES = 2,
  parameter int SW_W       = 2,
  parameter int STATE_W    = 3,
  parameter int ERR_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [SW_W-1:0]    cfg_sw,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic               cfg_out,
  input  logic               start,
  mealy_probe_if.master      dut,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               first_err_valid,
  output logic [STATE_W-1:0] first_err_state,
  output logic [SW_W-1:0]    first_err_sw,
  output logic [1:0]         first_err_kind
);
  localparam logic [SW_W-1:0]    SW_MAX = '1;
  localparam logic [STATE_W-1:0] S_LAST = STATE_W'(NUM_STATES - 1);

  state_e             st_q;
  logic [STATE_W-1:0] s_q, s_d;
  logic [SW_W-1:0]    i_q, i_d;
  logic               dut_reset_q, dut_ctrl_q;
  logic [STATE_W-1:0] dut_state_in_q;
  logic [SW_W-1:0]    dut_sw_q;
  logic               busy_q, done_q, pass_q, fev_q;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [STATE_W-1:0] fes_q;
  logic [SW_W-1:0]    fsw_q;
  logic [1:0]         fk_q, kind;
  logic               mis, last_pair, stop, tbl_we;
  entry_t             exp_e, wr_e;

  // Table is frozen during a sweep so the checked contents stay coherent.
  assign tbl_we = cfg_we && !busy_q && (int'(cfg_state) < NUM_STATES);
  assign wr_e   = '{next: MAX_STATE_W'(cfg_next), out: cfg_out};

  mealy_exp_table #(
    .NUM_STATES(NUM_STATES), .SW_W(SW_W), .STATE_W(STATE_W)
  ) u_tbl (
    .clk       (clk),
    .rst_n     (reset),
    .we_i      (tbl_we),
    .wr_state_i(cfg_state),
    .wr_sw_i   (cfg_sw),
    .wr_data_i (wr_e),
    .rd_state_i(s_q),
    .rd_sw_i   (i_q),
    .rd_data_o (exp_e)
  );

  always_comb begin
    kind           = '0;
    kind[ERR_NEXT] = (MAX_STATE_W'(dut.dut_state) != exp_e.next);
    kind[ERR_OUT]  = (dut.dut_out != exp_e.out);
    mis            = |kind;
    err_d          = (mis && (err_q != '1)) ? err_q + 1'b1 : err_q;
    last_pair      = (s_q == S_LAST) && (i_q == SW_MAX);
`ifdef MEALY_PROBE_STOP_ON_ERR_EN
    stop           = last_pair || mis;
`else
    stop           = last_pair;
`endif
    i_d            = i_q + 1'b1;
    s_d            = (i_q == SW_MAX) ? s_q + 1'b1 : s_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q           <= ST_IDLE;
      s_q            <= '0;
      i_q            <= '0;
      dut_reset_q    <= 1'b0;
      dut_ctrl_q     <= 1'b0;
      dut_state_in_q <= '0;
      dut_sw_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      err_q          <= '0;
      fev_q          <= 1'b0;
      fes_q          <= '0;
      fsw_q          <= '0;
      fk_q           <= '0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        ST_IDLE: if (start) begin
          st_q           <= ST_PRELOAD;
          busy_q         <= 1'b1;
          pass_q         <= 1'b0;
          err_q          <= '0;
          fev_q          <= 1'b0;
          fes_q          <= '0;
          fsw_q          <= '0;
          fk_q           <= '0;
          s_q            <= '0;
          i_q            <= '0;
          dut_reset_q    <= 1'b1;
          dut_state_in_q <= '0;
          dut_sw_q       <= '0;
        end
        ST_PRELOAD: begin
          st_q           <= ST_SETTLE;
          dut_reset_q    <= 1'b0;
          dut_state_in_q <= '0;
        end
        ST_SETTLE: begin
          st_q       <= ST_STEP;
          dut_ctrl_q <= 1'b1;
        end
        ST_STEP: begin
          st_q       <= ST_CHECK;
          dut_ctrl_q <= 1'b0;
          dut_sw_q   <= '0;
        end
        ST_CHECK: begin
          err_q <= err_d;
          if (mis && !fev_q) begin
            fev_q <= 1'b1;
            fes_q <= s_q;
            fsw_q <= i_q;
            fk_q  <= kind;
          end
          if (stop) begin
            st_q   <= ST_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            pass_q <= (err_d == '0);
          end else begin
            st_q           <= ST_PRELOAD;
            s_q            <= s_d;
            i_q            <= i_d;
            dut_reset_q    <= 1'b1;
            dut_state_in_q <= s_d;
            dut_sw_q       <= i_d;
          end
        end
        ST_DONE: st_q <= ST_IDLE;
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign dut.dut_reset    = dut_reset_q;
  assign dut.dut_state_in = dut_state_in_q;
  assign dut.dut_sw       = dut_sw_q;
  assign dut.dut_ctrl     = dut_ctrl_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_cnt          = err_q;
  assign first_err_valid  = fev_q;
  assign first_err_state  = fes_q;
  assign first_err_sw     = fsw_q;
  assign first_err_kind   = fk_q;
endmodule

// File: tb/tb_mealy_probe.sv
// Randomized + directed bench for mealy_probe: two probe instances (2x4 and 8x64
// sweeps) each driving a behavioural Mealy FSM defined by a lookup table.
module tb_mealy_probe;
  import mealy_probe_pkg::*;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic       grst_n;
  logic       s_we, b_we, s_start, b_start, cfg_out;
  logic [2:0] cfg_state, cfg_next;
  logic [5:0] cfg_sw;

  // Behavioural FSM tables (model) and expected tables (what the probe holds).
  logic [2:0] m_nx [2][8][64];
  bit         m_o  [2][8][64];
  logic [2:0] e_nx [2][8][64];
  bit         e_o  [2][8][64];

  int n_chk = 0, n_err = 0;
  int done_cnt [2];

  mealy_probe_if #(.STATE_W(3), .SW_W(2)) s_if ();
  mealy_probe_if #(.STATE_W(3), .SW_W(6)) b_if ();

  logic       s_busy, s_done, s_pass, s_fev, b_busy, b_done, b_pass, b_fev;
  logic [7:0] s_err, b_err;
  logic [2:0] s_fes, b_fes;
  logic [1:0] s_fsw, s_fk, b_fk;
  logic [5:0] b_fsw;

  mealy_probe #(.NUM_STATES(2), .SW_W(2), .STATE_W(3), .ERR_W(8)) u_small (
    .clk(gclk), .reset(grst_n), .cfg_we(s_we), .cfg_state(cfg_state), .cfg_sw(cfg_sw[1:0]),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .start(s_start), .dut(s_if),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err), .first_err_valid(s_fev),
    .first_err_state(s_fes), .first_err_sw(s_fsw), .first_err_kind(s_fk));

  mealy_probe #(.NUM_STATES(8), .SW_W(6), .STATE_W(3), .ERR_W(8)) u_big (
    .clk(gclk), .reset(grst_n), .cfg_we(b_we), .cfg_state(cfg_state), .cfg_sw(cfg_sw),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .start(b_start), .dut(b_if),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err), .first_err_valid(b_fev),
    .first_err_state(b_fes), .first_err_sw(b_fsw), .first_err_kind(b_fk));

  // FSMs under test: preload on dut_reset, step on dut_ctrl; out is never reset.
  logic [2:0] s_fsm, b_fsm;
  logic       s_fo, b_fo;
  always @(posedge gclk) begin
    if (s_if.dut_reset) s_fsm <= s_if.dut_state_in;
    else if (s_if.dut_ctrl) begin
      s_fsm <= m_nx[0][s_fsm][s_if.dut_sw];
      s_fo  <= m_o[0][s_fsm][s_if.dut_sw];
    end
    if (b_if.dut_reset) b_fsm <= b_if.dut_state_in;
    else if (b_if.dut_ctrl) begin
      b_fsm <= m_nx[1][b_fsm][b_if.dut_sw];
      b_fo  <= m_o[1][b_fsm][b_if.dut_sw];
    end
  end
  assign s_if.dut_state = s_fsm;
  assign s_if.dut_out   = s_fo;
  assign b_if.dut_state = b_fsm;
  assign b_if.dut_out   = b_fo;

  logic       o_done [2], o_busy [2], o_pass [2], o_fev [2];
  logic [7:0] o_err [2];
  logic [2:0] o_fes [2];
  logic [5:0] o_fsw [2];
  logic [1:0] o_fk [2];
  assign o_done[0] = s_done;  assign o_done[1] = b_done;
  assign o_busy[0] = s_busy;  assign o_busy[1] = b_busy;
  assign o_pass[0] = s_pass;  assign o_pass[1] = b_pass;
  assign o_fev[0]  = s_fev;   assign o_fev[1]  = b_fev;
  assign o_err[0]  = s_err;   assign o_err[1]  = b_err;
  assign o_fes[0]  = s_fes;   assign o_fes[1]  = b_fes;
  assign o_fsw[0]  = {4'b0, s_fsw};
  assign o_fsw[1]  = b_fsw;
  assign o_fk[0]   = s_fk;    assign o_fk[1]   = b_fk;

  always @(negedge gclk) begin
    if (s_done) done_cnt[0] <= done_cnt[0] + 1;
    if (b_done) done_cnt[1] <= done_cnt[1] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int n = 0; n < 2; n++)
      for (int s = 0; s < 8; s++)
        for (int i = 0; i < 64; i++) begin
          e_nx[n][s][i] = '0;
          e_o[n][s][i]  = 1'b0;
        end
  endtask

  task automatic wr(input int inst, input int s, input int i, input int nx, input bit o);
    @(negedge gclk);
    cfg_state = 3'(s); cfg_sw = 6'(i); cfg_next = 3'(nx); cfg_out = o;
    if (inst == 0) s_we = 1'b1; else b_we = 1'b1;
    @(negedge gclk);
    s_we = 1'b0; b_we = 1'b0;
    if (s < ((inst == 0) ? 2 : 8)) begin
      e_nx[inst][s][i] = 3'(nx);
      e_o[inst][s][i]  = o;
    end
  endtask

  // Reference: walk pairs in sweep order and tally differences between tables.
  task automatic ref_sweep(input int inst, output int err, output bit fev, output int fes,
                           output int fsw, output int fk, output int pairs);
    int ns, nsw, k;
    bit stopped;
    ns = (inst == 0) ? 2 : 8;
    nsw = (inst == 0) ? 4 : 64;
    err = 0; fev = 0; fes = 0; fsw = 0; fk = 0; pairs = 0; stopped = 0;
    for (int s = 0; s < ns && !stopped; s++)
      for (int i = 0; i < nsw && !stopped; i++) begin
        pairs++;
        k = ((m_nx[inst][s][i] != e_nx[inst][s][i]) ? 1 : 0) + ((m_o[inst][s][i] != e_o[inst][s][i]) ? 2 : 0);
        if (k != 0) begin
          if (err < 255) err++;
          if (!fev) begin fev = 1; fes = s; fsw = i; fk = k; end
`ifdef MEALY_PROBE_STOP_ON_ERR_EN
          stopped = 1;
`endif
        end
      end
  endtask

  task automatic run_sweep(input int inst, input string tag, input int poke_start,
                           input int poke_we, input bit done_start);
    int err, fes, fsw, fk, pairs, cyc, d0;
    bit fev;
    ref_sweep(inst, err, fev, fes, fsw, fk, pairs);
    d0 = done_cnt[inst];
    @(negedge gclk);
    if (inst == 0) s_start = 1'b1; else b_start = 1'b1;
    @(negedge gclk);
    s_start = 1'b0; b_start = 1'b0;
    cyc = 1;
    while (!o_done[inst] && cyc < 4 * 512 + 20) begin
      s_start = (inst == 0) && (cyc == poke_start);
      if (inst == 0 && cyc == poke_we) begin
        cfg_state = 3'd0; cfg_sw = 6'd0; cfg_next = 3'd7; cfg_out = ~e_o[0][0][0];
        s_we = 1'b1;
      end else s_we = 1'b0;
      @(negedge gclk);
      cyc++;
    end
    s_we = 1'b0;
    s_start = done_start && (inst == 0);
    chk({tag, " latency"}, cyc, 4 * pairs + 1);
    chk({tag, " busy@done"}, o_busy[inst], 0);
    chk({tag, " pass"}, o_pass[inst], (err == 0) ? 1 : 0);
    chk({tag, " err_cnt"}, o_err[inst], err);
    chk({tag, " first_err_valid"}, o_fev[inst], fev);
    if (fev) begin
      chk({tag, " first_err_state"}, o_fes[inst], fes);
      chk({tag, " first_err_sw"}, o_fsw[inst], fsw);
      chk({tag, " first_err_kind"}, o_fk[inst], fk);
    end
    @(negedge gclk);
    s_start = 1'b0;
    repeat (8) @(negedge gclk);
    chk({tag, " no restart"}, o_busy[inst], 0);
    chk({tag, " single done"}, done_cnt[inst] - d0, 1);
  endtask

  int tnx [8] = '{0, 0, 1, 1, 0, 1, 1, 1};
  bit tout [8] = '{1, 0, 1, 1, 0, 1, 1, 0};

  task automatic load_plan_table();
    for (int k = 0; k < 8; k++) wr(0, k / 4, k % 4, tnx[k], tout[k]);
  endtask

  task automatic model_from_exp(input int inst);
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < 64; i++) begin
        m_nx[inst][s][i] = e_nx[inst][s][i];
        m_o[inst][s][i]  = e_o[inst][s][i];
      end
  endtask

  initial begin
    int d0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    s_we = 0; b_we = 0; s_start = 0; b_start = 0;
    cfg_state = 0; cfg_sw = 0; cfg_next = 0; cfg_out = 0;
    grst_n = 1'b0;
    clear_exp();
    model_from_exp(0);
    model_from_exp(1);
    repeat (3) @(negedge gclk);
    grst_n = 1'b1;
    @(negedge gclk);
    chk("rst busy", s_busy, 0);
    chk("rst done", s_done, 0);
    chk("rst pass", s_pass, 0);
    chk("rst err_cnt", s_err, 0);
    chk("rst first_err", {s_fev, s_fes, s_fsw, s_fk}, 0);
    chk("rst dut bus", {s_if.dut_reset, s_if.dut_ctrl, s_if.dut_sw, s_if.dut_state_in}, 0);

    load_plan_table();
    model_from_exp(0);
    run_sweep(0, "clean", 0, 0, 0);

    m_nx[0][0][2] = 3'd0;
    m_o[0][1][0]  = 1'b1;
    run_sweep(0, "faulty", 0, 0, 0);

    model_from_exp(0);
    run_sweep(0, "busy pokes", 5, 9, 1);

    // Abort mid-sweep with reset during STEP of pair (1,1).
    d0 = done_cnt[0];
    @(negedge gclk); s_start = 1'b1;
    @(negedge gclk); s_start = 1'b0;
    repeat (22) @(negedge gclk);
    chk("abort step ctrl", s_if.dut_ctrl, 1);
    chk("abort step sw", s_if.dut_sw, 1);
    chk("abort busy before", s_busy, 1);
    #2 grst_n = 1'b0;
    #1;
    chk("abort outputs", {s_busy, s_done, s_pass, s_err, s_fev, s_fes, s_fsw, s_fk}, 0);
    chk("abort dut bus", {s_if.dut_reset, s_if.dut_ctrl, s_if.dut_sw, s_if.dut_state_in}, 0);
    clear_exp();
    repeat (2) @(negedge gclk);
    grst_n = 1'b1;
    repeat (4) @(negedge gclk);
    chk("abort no done", done_cnt[0] - d0, 0);
    load_plan_table();
    model_from_exp(0);
    run_sweep(0, "after abort", 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) wr(0, k / 4, k % 4, $urandom_range(0, 7), 1'($urandom));
      wr(0, $urandom_range(2, 7), $urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom));
      model_from_exp(0);
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) m_nx[0][k / 4][k % 4] = m_nx[0][k / 4][k % 4] + 3'($urandom_range(1, 7));
          else m_o[0][k / 4][k % 4] = ~m_o[0][k / 4][k % 4];
        end
      run_sweep(0, $sformatf("rand%0d", r), 0, 0, 0);
    end

    // Big config: cleared table vs. a model that faults the first 300 pairs.
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < 64; i++) begin
        m_nx[1][s][i] = (s * 64 + i < 300) ? 3'd1 : 3'd0;
        m_o[1][s][i]  = 1'b0;
      end
    run_sweep(1, "saturate", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
